// File: rtl/dmi_pkg.sv
// dmi_pkg: DMI op/resp/status codes, request/response field positions and FSM encoding for dmi_master.
package dmi_pkg;
  localparam logic [1:0] OP_READ = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] RESP_OK = 2'd0;
  localparam logic [1:0] RESP_RSVD = 2'd1;
  localparam logic [1:0] RESP_FAILED = 2'd2;
  localparam logic [1:0] RESP_BUSY = 2'd3;
  localparam logic [1:0] ST_OK = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_FAILED = 2'd2;
  localparam logic [1:0] ST_BUSY = 2'd3;
  localparam int REQ_W = 41;
  localparam int REQ_ADDR_LSB = 34;
  localparam int REQ_DATA_LSB = 2;
  localparam int RESP_W = 34;
  localparam int RESP_DATA_LSB = 2;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  // The reserved code is treated like a failure.
  function automatic logic [1:0] resp_status(input logic [1:0] r);
    return (r == RESP_FAILED || r == RESP_RSVD) ? ST_FAILED : r == RESP_BUSY ? ST_BUSY : ST_OK;
  endfunction
endpackage

// File: rtl/dmi_master_if.sv
// dmi_master_if: host command/response and DMI request/response signals of dmi_master.
interface dmi_master_if;
  import dmi_pkg::*;
  logic cmd_valid_i;
  logic cmd_ready_o;
  logic cmd_we_i;
  logic [6:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic rsp_valid_o;
  logic rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic [1:0] rsp_status_o;
  logic busy_o;
  logic dmi_req_valid_o;
  logic dmi_req_ready_i;
  logic [REQ_W-1:0] dmi_req_o;
  logic dmi_resp_valid_i;
  logic dmi_resp_ready_o;
  logic [RESP_W-1:0] dmi_resp_i;
  modport master (
    input cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i, dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_status_o, busy_o, dmi_req_valid_o, dmi_req_o, dmi_resp_ready_o
  );
  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i, dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_i,
    input cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_status_o, busy_o, dmi_req_valid_o, dmi_req_o, dmi_resp_ready_o
  );
endinterface

// File: rtl/dmi_master.sv
// dmi_master: host command to DMI request/response bridge with per-attempt timeout;
// define DMI_MASTER_BUSY_RETRY_EN to re-issue requests answered with busy (up to MaxRetries).
module dmi_master
  import dmi_pkg::*;
#(
  parameter int TimeoutCycles = 1023,
  parameter int MaxRetries = 15
) (
  input logic clk_i,
  input logic rst_i,
  dmi_master_if.master bus
);
`ifdef DMI_MASTER_BUSY_RETRY_EN
  localparam bit RetryEn = 1'b1;
`else
  localparam bit RetryEn = 1'b0;
`endif
  localparam int CW = $clog2(TimeoutCycles + 1);
  localparam int RW = $clog2(MaxRetries + 2);
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rty;
  logic [6:0] addr;
  logic we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [1:0] status;
  logic [1:0] resp;
  logic timeout;
  logic retry;
  // The last allowed cycle of an attempt is the abort cycle; a response arriving in it still wins.
  always_comb begin
    resp = bus.dmi_resp_i[RESP_DATA_LSB-1:0];
    timeout = (state == REQ || state == RESP) && cnt == CW'(TimeoutCycles - 1);
    retry = RetryEn && resp == RESP_BUSY && rty < RW'(MaxRetries);
    bus.cmd_ready_o = state == IDLE && !rst_i;
    bus.busy_o = state != IDLE;
    bus.dmi_req_valid_o = state == REQ;
    bus.dmi_resp_ready_o = state == RESP;
    bus.rsp_valid_o = state == DONE;
    bus.rsp_rdata_o = rdata;
    bus.rsp_status_o = status;
    bus.dmi_req_o = '0;
    if (state == REQ) begin
      bus.dmi_req_o[REQ_ADDR_LSB +: 7] = addr;
      bus.dmi_req_o[REQ_DATA_LSB +: 32] = we ? wdata : 32'h0;
      bus.dmi_req_o[REQ_DATA_LSB-1:0] = we ? OP_WRITE : OP_READ;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      rty <= '0;
      addr <= '0;
      we <= 1'b0;
      wdata <= '0;
      rdata <= '0;
      status <= ST_OK;
    end else begin
      if (state == REQ || state == RESP) cnt <= cnt == CW'(TimeoutCycles) ? cnt : cnt + CW'(1);
      case (state)
        IDLE: if (bus.cmd_valid_i) begin
          state <= REQ;
          cnt <= '0;
          rty <= '0;
          addr <= bus.cmd_addr_i;
          we <= bus.cmd_we_i;
          wdata <= bus.cmd_wdata_i;
        end
        REQ: if (timeout) begin
          state <= DONE;
          status <= ST_TIMEOUT;
          rdata <= '0;
        end else if (bus.dmi_req_ready_i) state <= RESP;
        RESP: if (bus.dmi_resp_valid_i) begin
          state <= retry ? REQ : DONE;
          rdata <= bus.dmi_resp_i[RESP_DATA_LSB +: 32];
          status <= resp_status(resp);
          if (retry) begin
            rty <= rty + RW'(1);
            cnt <= '0;
          end
        end else if (timeout) begin
          state <= DONE;
          status <= ST_TIMEOUT;
          rdata <= '0;
        end
        default: if (bus.rsp_ready_i) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmi_master.sv
// tb_dmi_master: directed self-checking bench for dmi_master (TimeoutCycles = 8, MaxRetries = 15).
module tb_dmi_master;
  import dmi_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int n;
  dmi_master_if bus();
  dmi_master #(.TimeoutCycles(8), .MaxRetries(15)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(negedge clk);
  endtask
  // Presents one command in IDLE; returns at the first negedge in REQ.
  task automatic issue(input logic we, input logic [6:0] addr, input logic [31:0] wdata);
    chk("cmd_ready_idle", bus.cmd_ready_o, 1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i = we;
    bus.cmd_addr_i = addr;
    bus.cmd_wdata_i = wdata;
    step;
    bus.cmd_valid_i = 1'b0;
  endtask
  task automatic ack;
    bus.rsp_ready_i = 1'b1;
    step;
    bus.rsp_ready_i = 1'b0;
    chk("back_idle", {bus.busy_o, bus.rsp_valid_o}, 0);
  endtask
  // DM answers busy to the first nbusy requests, then OK with data 0xBAD.
  task automatic serve(input int nbusy, input logic [40:0] exp_req, output int nreq);
    nreq = 0;
    bus.dmi_req_ready_i = 1'b1;
    for (int i = 0; i < 200 && !bus.rsp_valid_o; i++) begin
      if (bus.dmi_req_valid_o) begin
        nreq++;
        chk("req_same", bus.dmi_req_o, exp_req);
      end
      bus.dmi_resp_valid_i = bus.dmi_resp_ready_o;
      bus.dmi_resp_i = {32'h0000_0BAD, (nreq <= nbusy) ? RESP_BUSY : RESP_OK};
      step;
    end
    bus.dmi_resp_valid_i = 1'b0;
    bus.dmi_req_ready_i = 1'b0;
    chk("serve_done", bus.rsp_valid_o, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.cmd_valid_i = 0; bus.cmd_we_i = 0; bus.cmd_addr_i = 0; bus.cmd_wdata_i = 0;
    bus.rsp_ready_i = 0; bus.dmi_req_ready_i = 0; bus.dmi_resp_valid_i = 0; bus.dmi_resp_i = 0;
    step;
    step;
    chk("rst_outs", {bus.cmd_ready_o, bus.rsp_valid_o, bus.busy_o, bus.dmi_req_valid_o, bus.dmi_resp_ready_o}, 0);
    chk("rst_data", {bus.dmi_req_o, bus.rsp_status_o}, 0);
    chk("rst_rdata", bus.rsp_rdata_o, 0);
    rst = 1'b0;
    step;
    chk("post_rst_ready", bus.cmd_ready_o, 1);
    // Write 0x10 <- 1, DM ready/valid immediately: 3-cycle latency.
    bus.dmi_req_ready_i = 1'b1;
    bus.dmi_resp_valid_i = 1'b1;
    bus.dmi_resp_i = {32'hCAFE_0001, RESP_OK};
    issue(1'b1, 7'h10, 32'h0000_0001);
    chk("wr_req_valid", bus.dmi_req_valid_o, 1);
    chk("wr_req", bus.dmi_req_o, {7'h10, 32'h0000_0001, 2'b10});
    chk("wr_cmd_ready_busy", bus.cmd_ready_o, 0);
    step;
    chk("wr_resp_ready", {bus.dmi_resp_ready_o, bus.rsp_valid_o, bus.dmi_req_valid_o}, 3'b100);
    step;
    bus.dmi_req_ready_i = 1'b0;
    bus.dmi_resp_valid_i = 1'b0;
    chk("wr_done", {bus.rsp_valid_o, bus.rsp_status_o}, {1'b1, ST_OK});
    chk("wr_rdata", bus.rsp_rdata_o, 32'hCAFE_0001);
    ack;
    // Read 0x04: request stalled 2 cycles, response on the 5th RESP cycle.
    issue(1'b0, 7'h04, 32'hFFFF_FFFF);
    chk("rd_req0", bus.dmi_req_o, {7'h04, 32'h0, 2'b01});
    step;
    chk("rd_req1", bus.dmi_req_o, {7'h04, 32'h0, 2'b01});
    bus.dmi_req_ready_i = 1'b1;
    step;
    bus.dmi_req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rd_wait", {bus.dmi_resp_ready_o, bus.rsp_valid_o}, 2'b10);
      step;
    end
    bus.dmi_resp_valid_i = 1'b1;
    bus.dmi_resp_i = {32'hDEAD_BEEF, RESP_OK};
    step;
    bus.dmi_resp_valid_i = 1'b0;
    chk("rd_done", {bus.rsp_valid_o, bus.rsp_status_o}, {1'b1, ST_OK});
    chk("rd_rdata", bus.rsp_rdata_o, 32'hDEAD_BEEF);
    ack;
    // Timeout in RESP: request accepted, DM never answers.
    issue(1'b1, 7'h30, 32'hA5A5_A5A5);
    bus.dmi_req_ready_i = 1'b1;
    step;
    bus.dmi_req_ready_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("to_resp_wait", {bus.dmi_resp_ready_o, bus.rsp_valid_o}, 2'b10);
      step;
    end
    chk("to_resp_done", {bus.rsp_valid_o, bus.rsp_status_o, bus.dmi_resp_ready_o, bus.dmi_req_valid_o}, {1'b1, ST_TIMEOUT, 2'b00});
    chk("to_resp_rdata", bus.rsp_rdata_o, 0);
    ack;
    // Timeout in REQ: request valid drops without handshake.
    issue(1'b0, 7'h31, 32'h0);
    for (int i = 0; i < 8; i++) begin
      chk("to_req_wait", {bus.dmi_req_valid_o, bus.rsp_valid_o}, 2'b10);
      step;
    end
    chk("to_req_done", {bus.rsp_valid_o, bus.rsp_status_o, bus.dmi_req_valid_o, bus.dmi_req_o}, {1'b1, ST_TIMEOUT, 1'b0, 41'h0});
    ack;
    // Response on the timeout cycle wins; FAILED code, then held 10 cycles.
    issue(1'b0, 7'h40, 32'h0);
    bus.dmi_req_ready_i = 1'b1;
    step;
    bus.dmi_req_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) step;
    bus.dmi_resp_valid_i = 1'b1;
    bus.dmi_resp_i = {32'h1234_5678, RESP_FAILED};
    step;
    bus.dmi_resp_valid_i = 1'b0;
    chk("edge_status", {bus.rsp_valid_o, bus.rsp_status_o}, {1'b1, ST_FAILED});
    chk("edge_rdata", bus.rsp_rdata_o, 32'h1234_5678);
    for (int i = 0; i < 10; i++) begin
      step;
      chk("hold", {bus.rsp_valid_o, bus.cmd_ready_o, bus.rsp_status_o, bus.rsp_rdata_o}, {1'b1, 1'b0, ST_FAILED, 32'h1234_5678});
    end
    ack;
    // Reserved resp code maps to FAILED.
    bus.dmi_req_ready_i = 1'b1;
    bus.dmi_resp_valid_i = 1'b1;
    bus.dmi_resp_i = {32'h0F0F_0F0F, RESP_RSVD};
    issue(1'b0, 7'h05, 32'h0);
    step;
    step;
    bus.dmi_req_ready_i = 1'b0;
    bus.dmi_resp_valid_i = 1'b0;
    chk("rsvd_status", {bus.rsp_valid_o, bus.rsp_status_o}, {1'b1, ST_FAILED});
    chk("rsvd_rdata", bus.rsp_rdata_o, 32'h0F0F_0F0F);
    ack;
`ifdef DMI_MASTER_BUSY_RETRY_EN
    issue(1'b0, 7'h11, 32'h0);
    serve(2, {7'h11, 32'h0, 2'b01}, n);
    chk("retry_nreq", n, 3);
    chk("retry_status", {bus.rsp_status_o, bus.rsp_rdata_o}, {ST_OK, 32'h0000_0BAD});
    ack;
    issue(1'b1, 7'h12, 32'h0000_0055);
    serve(16, {7'h12, 32'h0000_0055, 2'b10}, n);
    chk("retry_max_nreq", n, 16);
    chk("retry_max_status", bus.rsp_status_o, ST_BUSY);
    ack;
`else
    issue(1'b1, 7'h11, 32'h0000_0077);
    serve(2, {7'h11, 32'h0000_0077, 2'b10}, n);
    chk("busy_nreq", n, 1);
    chk("busy_status", {bus.rsp_status_o, bus.rsp_rdata_o}, {ST_BUSY, 32'h0000_0BAD});
    ack;
`endif
    // Reset while in RESP discards the command.
    issue(1'b0, 7'h20, 32'h0);
    bus.dmi_req_ready_i = 1'b1;
    step;
    bus.dmi_req_ready_i = 1'b0;
    chk("mid_resp", bus.dmi_resp_ready_o, 1);
    rst = 1'b1;
    step;
    chk("mid_rst", {bus.busy_o, bus.rsp_valid_o, bus.dmi_req_valid_o, bus.dmi_resp_ready_o, bus.cmd_ready_o}, 0);
    rst = 1'b0;
    step;
    chk("mid_rst_ready", {bus.cmd_ready_o, bus.rsp_valid_o}, 2'b10);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("mid_rst_quiet", {bus.busy_o, bus.rsp_valid_o}, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
